// File: rtl/hsi_mse_pkg.sv
// Shared definitions for the HSI library-search sequencer.
// Holds the FSM state type and the default widths/limits that the
// controller and its min tracker use as parameter defaults.
package hsi_mse_pkg;

    localparam int HM_HSI_LIBRARY_SIZE = 256;  // largest accepted library
    localparam int HM_LENGTH_BITS      = 10;   // width of lib_size / band_count
    localparam int HM_DATA_WIDTH_ACC   = 48;   // MSE accumulator width
    localparam int HM_MSE_TIMEOUT      = 1024; // max WAIT_MSE dwell per entry

    typedef enum logic [2:0] {
        IDLE,
        READ_MEASURE,
        COMPUTE_MSE,
        WAIT_MSE,
        COMPARE_MSE,
        DONE
    } hsi_mse_lib_state_t;

endpackage

// File: rtl/hsi_mse_min_tracker.sv
// Running-minimum tracker for the library search.
//   clear   : accepted start; arms the first flag so the next update
//             always loads, whatever min_mse currently holds
//   upd_en  : one MSE result (value, idx) is presented for comparison
//   min_idx / min_mse : best index and its MSE so far
// Strict less-than keeps the lower index on ties, since entries arrive
// in ascending index order.
module hsi_mse_min_tracker #(
    parameter int IDX_WIDTH = 8,
    parameter int MSE_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 upd_en,
    input  logic [MSE_WIDTH-1:0] value,
    input  logic [IDX_WIDTH-1:0] idx,
    output logic [IDX_WIDTH-1:0] min_idx,
    output logic [MSE_WIDTH-1:0] min_mse
);

    logic                 first_q,   first_d;
    logic [IDX_WIDTH-1:0] min_idx_q, min_idx_d;
    logic [MSE_WIDTH-1:0] min_mse_q, min_mse_d;

    always_comb begin
        first_d   = first_q;
        min_idx_d = min_idx_q;
        min_mse_d = min_mse_q;
        if (clear) begin
            // Results from the previous search stay visible until the
            // first compare of the new one.
            first_d = 1'b1;
        end else if (upd_en && (first_q || (value < min_mse_q))) begin
            first_d   = 1'b0;
            min_idx_d = idx;
            min_mse_d = value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q   <= 1'b0;
            min_idx_q <= '0;
            min_mse_q <= '0;
        end else begin
            first_q   <= first_d;
            min_idx_q <= min_idx_d;
            min_mse_q <= min_mse_d;
        end
    end

    assign min_idx = min_idx_q;
    assign min_mse = min_mse_q;

endmodule

// File: rtl/hsi_mse_lib_ctrl.sv
// HSI library-search sequencer.
// On an accepted start it requests the measured pixel (meas_req/meas_ack),
// then for each library entry pulses mse_start, waits for mse_valid
// (bounded by TIMEOUT_CYCLES) and folds the result into the running
// minimum. Reports min_idx/min_mse, a one-cycle done pulse and a sticky
// error (bad config or datapath timeout).
//   clk, rst_n               : clock, async active-low reset
//   start, lib_size, band_count : host command/config
//   meas_req / meas_ack      : pixel loader handshake
//   mse_start, mse_lib_idx, mse_band_count, mse_valid, mse_value : MSE datapath
//   busy, done, error, min_idx, min_mse : status/result
module hsi_mse_lib_ctrl
    import hsi_mse_pkg::*;
#(
    parameter int LIB_SIZE_MAX   = HM_HSI_LIBRARY_SIZE,
    parameter int IDX_WIDTH      = $clog2(LIB_SIZE_MAX),
    parameter int LENGTH_BITS    = HM_LENGTH_BITS,
    parameter int MSE_WIDTH      = HM_DATA_WIDTH_ACC,
    parameter int TIMEOUT_CYCLES = HM_MSE_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LENGTH_BITS-1:0] lib_size,
    input  logic [LENGTH_BITS-1:0] band_count,
    output logic                   meas_req,
    input  logic                   meas_ack,
    output logic                   mse_start,
    output logic [IDX_WIDTH-1:0]   mse_lib_idx,
    output logic [LENGTH_BITS-1:0] mse_band_count,
    input  logic                   mse_valid,
    input  logic [MSE_WIDTH-1:0]   mse_value,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [IDX_WIDTH-1:0]   min_idx,
    output logic [MSE_WIDTH-1:0]   min_mse
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    hsi_mse_lib_state_t     state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [IDX_WIDTH-1:0]   last_q, last_d;      // lib_size-1, latched
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [LENGTH_BITS-1:0] band_q, band_d;
    logic                   err_q, err_d;
    logic [MSE_WIDTH-1:0]   val_q, val_d;
    logic                   meas_req_q, mse_start_q, busy_q, done_q;
    logic [IDX_WIDTH-1:0]   mse_lib_idx_q, mse_lib_idx_d;
    logic                   trk_clear, trk_upd, cfg_ok;

    assign cfg_ok = (lib_size != '0) && (32'(lib_size) <= 32'(LIB_SIZE_MAX))
                    && (band_count != '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        timer_d   = timer_q;
        band_d    = band_q;
        err_d     = err_q;
        val_d     = val_q;
        trk_clear = 1'b0;
        trk_upd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        last_d    = IDX_WIDTH'(lib_size - 1'b1);
                        band_d    = band_count;
                        err_d     = 1'b0;
                        trk_clear = 1'b1;
                        state_d   = READ_MEASURE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            READ_MEASURE: begin
                if (meas_ack) begin
                    idx_d   = '0;
                    state_d = COMPUTE_MSE;
                end
            end
            COMPUTE_MSE: begin
                timer_d = '0;
                state_d = WAIT_MSE;
            end
            WAIT_MSE: begin
                // A result arriving on the last allowed cycle still counts.
                if (mse_valid) begin
                    val_d   = mse_value;
                    state_d = COMPARE_MSE;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            COMPARE_MSE: begin
                trk_upd = 1'b1;
                if (idx_q == last_q) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = COMPUTE_MSE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mse_lib_idx_d = (state_d == COMPUTE_MSE) ? idx_d : mse_lib_idx_q;
    end

    // Outputs are decoded from the next state so they line up with the
    // state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            last_q        <= '0;
            timer_q       <= '0;
            band_q        <= '0;
            err_q         <= 1'b0;
            val_q         <= '0;
            meas_req_q    <= 1'b0;
            mse_start_q   <= 1'b0;
            mse_lib_idx_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            band_q        <= band_d;
            err_q         <= err_d;
            val_q         <= val_d;
            meas_req_q    <= (state_d == READ_MEASURE);
            mse_start_q   <= (state_d == COMPUTE_MSE);
            mse_lib_idx_q <= mse_lib_idx_d;
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == DONE);
        end
    end

    hsi_mse_min_tracker #(
        .IDX_WIDTH (IDX_WIDTH),
        .MSE_WIDTH (MSE_WIDTH)
    ) u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (trk_clear),
        .upd_en  (trk_upd),
        .value   (val_q),
        .idx     (idx_q),
        .min_idx (min_idx),
        .min_mse (min_mse)
    );

    assign meas_req       = meas_req_q;
    assign mse_start      = mse_start_q;
    assign mse_lib_idx    = mse_lib_idx_q;
    assign mse_band_count = band_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;

endmodule

// File: tb/tb_hsi_mse_lib_ctrl.sv
// Self-checking bench for hsi_mse_lib_ctrl: acts as pixel loader and MSE
// datapath with random response delays; expected minima come from a
// plain argmin over the value table.
module tb_hsi_mse_lib_ctrl;

    localparam int IW = 8;
    localparam int LB = 10;
    localparam int MW = 48;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LB-1:0] lib_size = '0;
    logic [LB-1:0] band_count = '0;
    logic          meas_ack = 1'b0;
    logic          mse_valid = 1'b0;
    logic [MW-1:0] mse_value = '0;
    logic          meas_req, mse_start, busy, done, error;
    logic [IW-1:0] mse_lib_idx, min_idx;
    logic [LB-1:0] mse_band_count;
    logic [MW-1:0] min_mse;

    int n_chk = 0;
    int n_fail = 0;
    logic [MW-1:0] vals [256];
    logic [IW-1:0] exp_idx = '0;
    logic [MW-1:0] exp_mse = '0;

    hsi_mse_lib_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lib_size(lib_size),
        .band_count(band_count), .meas_req(meas_req), .meas_ack(meas_ack),
        .mse_start(mse_start), .mse_lib_idx(mse_lib_idx),
        .mse_band_count(mse_band_count), .mse_valid(mse_valid),
        .mse_value(mse_value), .busy(busy), .done(done), .error(error),
        .min_idx(min_idx), .min_mse(min_mse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: index of the smallest value, earliest index on ties.
    function automatic void ref_search(input int n);
        for (int i = 0; i < n; i++)
            if (i == 0 || vals[i] < exp_mse) begin
                exp_mse = vals[i];
                exp_idx = IW'(i);
            end
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_error"}, 64'(error), 0);
        chk({tag, "_meas_req"}, 64'(meas_req), 0);
        chk({tag, "_mse_start"}, 64'(mse_start), 0);
        chk({tag, "_lib_idx"}, 64'(mse_lib_idx), 0);
        chk({tag, "_band"}, 64'(mse_band_count), 0);
        chk({tag, "_min_idx"}, 64'(min_idx), 0);
        chk({tag, "_min_mse"}, 64'(min_mse), 0);
    endtask

    // One search over vals[0..n-1]. spur injects ignored inputs;
    // rst_at >= 0 pulls reset while waiting on that entry.
    task automatic do_run(input int n, input int bc, input bit spur, input int rst_at);
        int  cyc = 0, vcnt = 0, cur = -1, starts = 0, ack_dly;
        bit  acked = 0, fin = 0, rst_hit = 0;
        ack_dly = spur ? 2 : int'($urandom_range(0, 3));
        lib_size = LB'(n); band_count = LB'(bc); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("meas_req_lat", 64'(meas_req), 1);
        chk("err_clr", 64'(error), 0);
        chk("busy_run", 64'(busy), 1);
        while (!fin && cyc < 6000) begin
            meas_ack = 1'b0; mse_valid = 1'b0; start = 1'b0;
            if (rst_at >= 0 && cur == rst_at && vcnt > 0) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                exp_idx = '0; exp_mse = '0;
                rst_hit = 1; fin = 1;
            end else begin
                if (meas_req && !acked) begin
                    if (ack_dly == 0) begin
                        meas_ack = 1'b1; acked = 1;
                    end else begin
                        ack_dly--;
                        if (spur) begin mse_valid = 1'b1; mse_value = '0; end
                    end
                end
                if (vcnt > 0) begin
                    vcnt--;
                    if (vcnt == 0) begin
                        mse_valid = 1'b1; mse_value = vals[cur];
                    end else if (spur) begin
                        start = 1'b1; lib_size = LB'(1);
                    end
                end
                if (mse_start) begin
                    starts++; cur++;
                    chk("mse_lib_idx", 64'(mse_lib_idx), 64'(cur));
                    chk("band_fwd", 64'(mse_band_count), 64'(bc));
                    vcnt = int'($urandom_range(spur ? 2 : 1, 5));
                end
                if (done) begin
                    fin = 1;
                    chk("done_busy", 64'(busy), 1);
                    chk("run_err", 64'(error), 0);
                end
                @(negedge clk);
                cyc++;
            end
        end
        mse_valid = 1'b0; start = 1'b0; meas_ack = 1'b0;
        if (rst_hit) begin
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end else begin
            chk("done_seen", 64'(fin), 1);
            chk("done_pulse", 64'(done), 0);
            chk("busy_idle", 64'(busy), 0);
            chk("starts", 64'(starts), 64'(n));
            ref_search(n);
            chk("min_idx", 64'(min_idx), 64'(exp_idx));
            chk("min_mse", 64'(min_mse), 64'(exp_mse));
        end
    endtask

    task automatic do_bad(input int ls, input int bc);
        int mreq = 0, mst = 0, dn = 0;
        lib_size = LB'(ls); band_count = LB'(bc); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_done_lat", 64'(done), 1);
        for (int i = 0; i < 6; i++) begin
            mreq += int'(meas_req); mst += int'(mse_start); dn += int'(done);
            if (done) chk("bad_err", 64'(error), 1);
            @(negedge clk);
        end
        chk("bad_meas_req", 64'(mreq), 0);
        chk("bad_mse_start", 64'(mst), 0);
        chk("bad_done_cnt", 64'(dn), 1);
        chk("bad_err_sticky", 64'(error), 1);
        chk("bad_min_idx", 64'(min_idx), 64'(exp_idx));
        chk("bad_min_mse", 64'(min_mse), 64'(exp_mse));
    endtask

    task automatic do_timeout();
        int cyc = 0, c_st = -1, d = -1, starts = 0;
        bit fin = 0;
        lib_size = LB'(2); band_count = LB'(16); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            meas_ack = meas_req;
            if (mse_start) begin starts++; c_st = cyc; end
            if (done) begin fin = 1; d = cyc; chk("to_err", 64'(error), 1); end
            @(negedge clk);
            cyc++;
        end
        meas_ack = 1'b0;
        chk("to_seen", 64'(fin), 1);
        chk("to_cycles", 64'(d - (c_st + 1)), 64'(TO));
        chk("to_starts", 64'(starts), 1);
        chk("to_min_idx", 64'(min_idx), 64'(exp_idx));
        chk("to_min_mse", 64'(min_mse), 64'(exp_mse));
        chk("to_idle", 64'(busy), 0);
    endtask

    task automatic load_nominal();
        vals[0] = 48'd500; vals[1] = 48'd200; vals[2] = 48'd300; vals[3] = 48'd200;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        load_nominal();
        do_run(4, 128, 0, -1);

        vals[0] = {MW{1'b1}};
        do_run(1, 5, 0, -1);

        do_bad(0, 128);
        do_bad(257, 128);
        do_bad(300, 128);
        do_bad(4, 0);

        load_nominal();
        do_run(4, 128, 0, -1);

        do_timeout();

        load_nominal();
        do_run(4, 128, 1, -1);

        do_run(4, 128, 0, 2);
        do_run(4, 128, 0, -1);

        for (int r = 0; r < 20; r++) begin
            int n;
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++)
                vals[i] = (r % 2 == 0) ? MW'($urandom_range(0, 7))
                                       : MW'({$urandom(), $urandom()});
            do_run(n, int'($urandom_range(1, 1023)), 0, -1);
        end

        for (int i = 0; i < 256; i++) vals[i] = MW'($urandom_range(10, 5000));
        do_run(256, 1023, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hsi_mse_lib_ctrl.md
Name: hsi_mse_lib_ctrl

Overview:
Sequencer for the HSI library search. On start it requests loading of the measured pixel, then runs the MSE datapath once per library entry (index 0..lib_size-1). It compares each MSE result against the running minimum and reports the best-matching index and its MSE value. It sits between the host/config interface and the MSE datapath; the MSE datapath and the pixel loader are external.

Parameters:
LIB_SIZE_MAX, HM_HSI_LIBRARY_SIZE (256), largest accepted library size
IDX_WIDTH, $clog2(LIB_SIZE_MAX) (8), library index width
LENGTH_BITS, HM_LENGTH_BITS (10), width of lib_size and band_count
MSE_WIDTH, HM_DATA_WIDTH_ACC (48), MSE result width
TIMEOUT_CYCLES, 1024, maximum WAIT_MSE dwell per entry

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin search; sampled only in IDLE
lib_size  in  LENGTH_BITS  number of library entries; sampled on accepted start
band_count  in  LENGTH_BITS  bands per pixel; sampled on accepted start, forwarded
meas_req  out  1  pixel-load request; held until meas_ack
meas_ack  in  1  pixel loaded
mse_start  out  1  one-cycle pulse: compute MSE for mse_lib_idx
mse_lib_idx  out  IDX_WIDTH  library entry under computation
mse_band_count  out  LENGTH_BITS  latched band_count
mse_valid  in  1  mse_value valid; honoured only in WAIT_MSE
mse_value  in  MSE_WIDTH  MSE result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
error  out  1  sticky until next accepted start
min_idx  out  IDX_WIDTH  index of smallest MSE
min_mse  out  MSE_WIDTH  smallest MSE

Behaviour:
- The FSM uses the package type hsi_mse_lib_state_t: IDLE, READ_MEASURE, COMPUTE_MSE, WAIT_MSE, COMPARE_MSE, DONE.
- Reset (asynchronous, any state): state=IDLE. All outputs are 0 (min_mse=0, min_idx=0, error=0). Internal index and timer are 0.
- IDLE:
  - start=1 with lib_size in 1..LIB_SIZE_MAX and band_count != 0: latch config, clear error, set first flag, go to READ_MEASURE.
  - start=1 with invalid config: error=1, go to DONE. min_* are left unchanged.
- READ_MEASURE: meas_req=1. On meas_ack=1, go to COMPUTE_MSE with idx=0.
- COMPUTE_MSE: exactly one cycle. mse_start=1 and mse_lib_idx=idx. Clear the timer. Go to WAIT_MSE.
- WAIT_MSE:
  - mse_valid=1: register mse_value, go to COMPARE_MSE.
  - Otherwise the timer increments. When the timer reaches TIMEOUT_CYCLES-1 without mse_valid: error=1, go to DONE.
  - mse_valid and timeout in the same cycle: mse_valid wins.
- COMPARE_MSE:
  - If first flag is set, or value < min_mse (strict): min_mse=value, min_idx=idx, clear first flag. Ties keep the lower index.
  - If idx == lib_size-1, go to DONE. Otherwise idx++ and go to COMPUTE_MSE.
- DONE: done=1 for one cycle, go to IDLE. min_* hold until the next accepted start's first COMPARE_MSE.
- Ignored inputs: start outside IDLE; mse_valid outside WAIT_MSE; meas_ack outside READ_MEASURE.
- mse_lib_idx holds its value outside COMPUTE_MSE. mse_band_count holds the latched value.
- Latency: start to meas_req = 1 cycle. Per entry = 1 (COMPUTE) + W (WAIT cycles, including the cycle mse_valid is seen) + 1 (COMPARE). done asserts 1 cycle after the last COMPARE.
- Comparison is unsigned, full MSE_WIDTH. No truncation.

Decomposition:
- hsi_mse_pkg holds hsi_mse_lib_state_t, plus HM_HSI_LIBRARY_SIZE, HM_LENGTH_BITS and HM_DATA_WIDTH_ACC as parameter defaults.
- Add HM_MSE_TIMEOUT = 1024 to the package.
- One sub-module is natural: hsi_mse_min_tracker (first flag, strict compare, min_mse/min_idx registers, clear on start).

Test Plan:
- Nominal: lib_size=4, band_count=128, MSEs 500, 200, 300, 200 (mse_valid 3 cycles after each mse_start) -> min_idx=1, min_mse=200, done 1 pulse, busy low after DONE, error=0.
- All-ones: lib_size=1, MSE=48'hFFFF_FFFF_FFFF -> min_idx=0, min_mse=all-ones (first flag forces update).
- Bad config: start with lib_size=0, then lib_size=257 (then 300), then band_count=0 -> error=1, done pulse, no meas_req, no mse_start, min_* unchanged.
- Timeout: lib_size=2, never assert mse_valid -> error=1 and done exactly TIMEOUT_CYCLES cycles after the first WAIT_MSE cycle; mse_start pulsed once.
- Spurious inputs: mse_valid=1 during READ_MEASURE and start=1 during WAIT_MSE -> no state change, no restart, final result matches the nominal run.
- Reset mid-run: deassert rst_n during WAIT_MSE at idx=2 -> immediately IDLE with all outputs 0; a following nominal run completes correctly.
